sram_1rw_port_ctrl: RTL and testbench

- Initiator for the single-port OpenRAM macro's 1RW port: converts a valid/ready host request stream into registered csb0/web0/addr0/din0 commands and captures dout0 into a response FIFO.
- Handles macro read timing: address sampled at posedge, data driven after negedge, held until shortly after the next posedge.
- Optional post-reset clear sweep writes INIT_VALUE to every word.
- Sits between the fabric and the SRAM macro.

---
 rtl/sram_1rw_port_ctrl.sv | 149 ++++++++++++++
 tb/tb_sram_1rw_port_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_port_ctrl.sv
// sram_1rw_port_ctrl
//   Host-side initiator for the 1RW port of a single-port OpenRAM macro.
//   A valid/ready request stream is turned into registered macro commands
//   (csb0/web0/addr0/din0). Read data (dout0) is captured two cycles after
//   acceptance into a small response FIFO. A credit check keeps the FIFO
//   from overflowing. After reset, an optional sweep writes INIT_VALUE to
//   every word.
// Ports:
//   clk0, rst_n                       clock shared with the macro; async active-low reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                host request channel
//   rsp_valid/rsp_ready/rsp_rdata     read response channel, in request order
//   init_done                         high once the controller is in RUN
//   csb0/web0/addr0/din0/dout0        macro port (csb0/web0 active low)
module sram_1rw_port_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    RSP_DEPTH  = 4,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  csb_d, web_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d;

  // Read tracking: [1] = command on the macro pins, [2] = macro driving dout0.
  logic                  rd_acc;
  logic [2:1]            vld_pipe;

  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic [CW+1:0]         credit;
  logic                  accept, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every read in flight owns a FIFO slot, so a new request is only taken
  // while a slot is guaranteed free by the time its data lands.
  assign credit    = (CW+2)'(fifo_cnt) + (CW+2)'(vld_pipe[1]) + (CW+2)'(vld_pipe[2]);
  assign req_ready = (state_q == ST_RUN) && (credit < (CW+2)'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && !req_we;
  assign init_done = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    addr_d  = addr0;
    din_d   = din0;
    case (state_q)
      ST_INIT: begin
        if (INIT_EN != 0) begin
          csb_d  = 1'b0;
          web_d  = 1'b0;
          addr_d = cnt_q;
          din_d  = INIT_VALUE;
          cnt_d  = cnt_q + 1'b1;   // wraps back to 0 after the last word
          if (&cnt_q) state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          csb_d  = 1'b0;
          web_d  = ~req_we;
          addr_d = req_addr;
          din_d  = req_wdata;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      csb0     <= 1'b1;
      web0     <= 1'b1;
      addr0    <= '0;
      din0     <= '0;
      vld_pipe <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csb0     <= csb_d;
      web0     <= web_d;
      addr0    <= addr_d;
      din0     <= din_d;
      vld_pipe <= {vld_pipe[1], rd_acc};
    end
  end

  // dout0 is valid from the negedge after the macro samples the read until
  // just after the following posedge, so it is captured on that posedge.
  assign push      = vld_pipe[2];
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_rdata = fifo_mem[rd_ptr];

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= dout0;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_1rw_port_ctrl.sv
// Testbench for sram_1rw_port_ctrl: macro behavioural model, directed vector
// table, hand sequences for sweep/backpressure/reset, and randomized traffic
// checked against a transaction-level reference (shadow memory + response queue).
module tb_sram_1rw_port_ctrl;
  localparam int          DW     = 32;
  localparam int          AW     = 4;
  localparam int          DEPTH  = 16;
  localparam int          RSPD   = 4;
  localparam logic [31:0] INIT_V = 32'hA5A5A5A5;

  logic          clk0 = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done, csb0, web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;

  logic          b_req_ready, b_rsp_valid, b_init_done, b_csb0, b_web0;
  logic [DW-1:0] b_rsp_rdata, b_din0;
  logic [AW-1:0] b_addr0;
  logic [DW-1:0] b_dout0 = '0;

  always #5 clk0 = ~clk0;

  sram_1rw_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RSPD),
                       .INIT_EN(1), .INIT_VALUE(INIT_V)) dut (
    .clk0(clk0), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .csb0(csb0), .web0(web0), .addr0(addr0),
    .din0(din0), .dout0(dout0));

  // Second instance without the clear sweep; left idle.
  sram_1rw_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RSPD),
                       .INIT_EN(0), .INIT_VALUE(INIT_V)) dut_b (
    .clk0(clk0), .rst_n(rst_n), .req_valid(1'b0), .req_ready(b_req_ready),
    .req_we(1'b0), .req_addr(4'h0), .req_wdata(32'h0),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(b_rsp_rdata),
    .init_done(b_init_done), .csb0(b_csb0), .web0(b_web0), .addr0(b_addr0),
    .din0(b_din0), .dout0(b_dout0));

  // Macro model: command sampled at posedge, read data driven after negedge.
  logic [DW-1:0] mem [DEPTH];
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_a = '0;
  always @(posedge clk0) begin
    rd_pend <= !csb0 && web0;
    rd_a    <= addr0;
    if (!csb0 && !web0) mem[addr0] <= din0;
  end
  always @(negedge clk0) if (rd_pend) dout0 <= mem[rd_a];

  int ovf_errs = 0;
  always @(posedge clk0)
    if (rst_n && dut.vld_pipe[2] && dut.fifo_cnt == RSPD) ovf_errs++;

  // Reference model
  typedef struct { logic [DW-1:0] data; int avail; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] tbl_q[$];
  logic [DW-1:0] shadow [DEPTH];
  int            cyc = 0;
  int            tests = 0, fails = 0;

  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] exp; } vec_t;
  vec_t vecs[19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One RUN-mode clock: predict acceptance/pop from the model, advance, then check.
  task automatic step();
    bit            acc, pop, we_s;
    logic [AW-1:0] a_s;
    logic [DW-1:0] wd_s, rd_seen, t;
    exp_t          h;
    acc     = req_valid && (exp_q.size() < RSPD);
    pop     = rsp_ready && exp_q.size() > 0 && exp_q[0].avail <= cyc;
    we_s    = req_we; a_s = req_addr; wd_s = req_wdata; rd_seen = rsp_rdata;
    @(posedge clk0); #1;
    cyc++;
    if (pop) begin
      h = exp_q.pop_front();
      if (tbl_q.size() > 0) begin
        t = tbl_q.pop_front();
        chk("tbl_rdata", rd_seen, t);
      end
    end
    if (acc) begin
      chk("cmd_csb0", csb0, 0);
      chk("cmd_web0", web0, !we_s);
      chk("cmd_addr0", addr0, a_s);
      if (we_s) begin
        chk("cmd_din0", din0, wd_s);
        shadow[a_s] = wd_s;
      end else exp_q.push_back('{shadow[a_s], cyc + 2});
    end else begin
      chk("idle_csb0", csb0, 1);
      chk("idle_web0", web0, 1);
    end
    chk("req_ready", req_ready, exp_q.size() < RSPD);
    h.data  = '0;
    h.avail = 0;
    if (exp_q.size() > 0) h = exp_q[0];
    chk("rsp_valid", rsp_valid, exp_q.size() > 0 && h.avail <= cyc);
    if (exp_q.size() > 0 && h.avail <= cyc) chk("rsp_rdata", rsp_rdata, h.data);
  endtask

  task automatic drain();
    req_valid = 0;
    rsp_ready = 1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_csb0"}, csb0, 1);
    chk({tag, "_web0"}, web0, 1);
    chk({tag, "_addr0"}, addr0, 0);
    chk({tag, "_din0"}, din0, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_b_init_done"}, b_init_done, 0);
  endtask

  task automatic sweep_chk();
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk0); #1;
      chk("sweep_csb0", csb0, 0);
      chk("sweep_web0", web0, 0);
      chk("sweep_addr0", addr0, k - 1);
      chk("sweep_din0", din0, INIT_V);
      chk("sweep_init_done", init_done, k == DEPTH);
      chk("sweep_req_ready", req_ready, k == DEPTH);
      chk("sweep_rsp_valid", rsp_valid, 0);
      if (k == 1) begin
        chk("b_init_done", b_init_done, 1);
        chk("b_req_ready", b_req_ready, 1);
      end
      chk("b_csb0", b_csb0, 1);
    end
    for (int i = 0; i < DEPTH; i++) shadow[i] = INIT_V;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    logic [DW-1:0] held;
    vecs[0] = '{0, 4'd7, 32'h0, INIT_V};
    vecs[1] = '{1, 4'd3, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{0, 4'd3, 32'h0, 32'hDEADBEEF};
    for (int i = 0; i < 8; i++) begin
      vecs[3 + i]  = '{1, AW'(i), DW'(i * 3), 32'h0};
      vecs[11 + i] = '{0, AW'(i), 32'h0, DW'(i * 3)};
    end

    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 1;
    #2 rst_n = 0;
    repeat (3) @(posedge clk0);
    #1 reset_chk("por");
    rst_n = 1;
    sweep_chk();

    // Directed table: read after sweep, write->read same address, stream
    for (int i = 0; i < 19; i++) begin
      req_valid = 1;
      req_we    = vecs[i].we;
      req_addr  = vecs[i].addr;
      req_wdata = vecs[i].wdata;
      if (!vecs[i].we) tbl_q.push_back(vecs[i].exp);
      step();
    end
    drain();
    chk("tbl_all_seen", tbl_q.size(), 0);

    // Backpressure: continuous reads with rsp_ready low
    rsp_ready = 0; req_valid = 1; req_we = 0; acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'(i);
      if (req_ready) acc_n++;
      step();
    end
    chk("bp_accepts", acc_n, 4);
    held = rsp_rdata;
    req_valid = 0;
    repeat (3) step();
    chk("bp_held_valid", rsp_valid, 1);
    chk("bp_held_stable", rsp_rdata, held);
    chk("bp_held_head", rsp_rdata, 32'h0);
    drain();
    chk("bp_ready_back", req_ready, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Idle
    req_valid = 0;
    repeat (10) step();

    // Reset one cycle after accepting a read
    req_valid = 1; req_we = 0; req_addr = 4'd5;
    step();
    req_valid = 0;
    step();
    rst_n = 0;
    #1 reset_chk("midrst");
    exp_q.delete();
    tbl_q.delete();
    repeat (2) @(posedge clk0);
    #1 chk("midrst_rsp_valid", rsp_valid, 0);
    rst_n = 1;
    sweep_chk();
    repeat (5) step();

    chk("no_overflow", ovf_errs, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
